// File: rtl/rect_flip_sequencer.sv
// Rectangle-corner flip sequencer: scans every rectangle of a ROWS x COLS bit matrix,
// one per cycle, XOR-flipping qualifying corners until a pass is clean or the pass limit is hit.
module rect_flip_sequencer #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int MAX_PASSES = 8,
  parameter  int CNT_W      = 16,
  localparam int N          = ROWS * COLS,
  localparam int PC_W       = $clog2(MAX_PASSES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     m_in,
  input  logic             rule,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     m_out,
  output logic [CNT_W-1:0] flip_count,
  output logic [PC_W-1:0]  pass_count,
  output logic             converged
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0]   R1_LAST = RW'(ROWS - 2);
  localparam logic [RW-1:0]   R2_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]   C1_LAST = CW'(COLS - 2);
  localparam logic [CW-1:0]   C2_LAST = CW'(COLS - 1);
  localparam logic [PC_W-1:0] P_MAX   = PC_W'(MAX_PASSES);
  localparam logic [N-1:0]    ONE     = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_out_valid;
  logic [N-1:0]      r_mat;
  logic              r_rule;
  logic [CNT_W-1:0]  r_flip_cnt;
  logic [PC_W-1:0]   r_pass_cnt;
  logic              r_conv;
  logic              r_pass_flip;
  logic [RW-1:0]     r_r1, r_r2;
  logic [CW-1:0]     r_c1, r_c2;

  logic [N-1:0]      w_m11, w_m12, w_m21, w_m22, w_mask;
  logic              w_k11, w_k12, w_k21, w_k22;
  logic [2:0]        w_ones;
  logic              w_qual;
  logic              w_last;
  logic              w_pass_flip;
  logic [RW-1:0]     w_r1_inc;
  logic [CW-1:0]     w_c1_inc;

  // Element (r,c) lives at bit N-1-(r*COLS+c): row 0, column 0 is the MSB.
  function automatic int bit_idx(input int r, input int c);
    return N - 1 - (r * COLS + c);
  endfunction

  always_comb begin
    w_m11       = ONE << bit_idx(int'(r_r1), int'(r_c1));
    w_m12       = ONE << bit_idx(int'(r_r1), int'(r_c2));
    w_m21       = ONE << bit_idx(int'(r_r2), int'(r_c1));
    w_m22       = ONE << bit_idx(int'(r_r2), int'(r_c2));
    w_mask      = w_m11 | w_m12 | w_m21 | w_m22;
    w_k11       = |(r_mat & w_m11);
    w_k12       = |(r_mat & w_m12);
    w_k21       = |(r_mat & w_m21);
    w_k22       = |(r_mat & w_m22);
    w_ones      = {2'b00, w_k11} + {2'b00, w_k12} + {2'b00, w_k21} + {2'b00, w_k22};
    w_qual      = r_rule ? (w_ones >= 3'd3) : (w_ones == 3'd4);
    w_last      = (r_r1 == R1_LAST) && (r_r2 == R2_LAST) &&
                  (r_c1 == C1_LAST) && (r_c2 == C2_LAST);
    w_pass_flip = r_pass_flip | w_qual;
    w_r1_inc    = r_r1 + 1'b1;
    w_c1_inc    = r_c1 + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_mat       <= '0;
      r_rule      <= 1'b0;
      r_flip_cnt  <= '0;
      r_pass_cnt  <= '0;
      r_conv      <= 1'b0;
      r_pass_flip <= 1'b0;
      r_r1        <= '0;
      r_r2        <= RW'(1);
      r_c1        <= '0;
      r_c2        <= CW'(1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mat       <= m_in;
            r_rule      <= rule;
            r_flip_cnt  <= '0;
            r_pass_cnt  <= '0;
            r_conv      <= 1'b0;
            r_pass_flip <= 1'b0;
            r_r1        <= '0;
            r_r2        <= RW'(1);
            r_c1        <= '0;
            r_c2        <= CW'(1);
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_qual) begin
            r_mat <= r_mat ^ w_mask;
            if (r_flip_cnt != '1) r_flip_cnt <= r_flip_cnt + 1'b1;
          end
          r_pass_flip <= w_pass_flip;
          // Iterator: c2 innermost, then c1, r2, r1.
          if (!w_last) begin
            if (r_c2 != C2_LAST) begin
              r_c2 <= r_c2 + 1'b1;
            end else if (r_c1 != C1_LAST) begin
              r_c1 <= w_c1_inc;
              r_c2 <= w_c1_inc + 1'b1;
            end else if (r_r2 != R2_LAST) begin
              r_r2 <= r_r2 + 1'b1;
              r_c1 <= '0;
              r_c2 <= CW'(1);
            end else begin
              r_r1 <= w_r1_inc;
              r_r2 <= w_r1_inc + 1'b1;
              r_c1 <= '0;
              r_c2 <= CW'(1);
            end
          end else begin
            r_pass_cnt  <= r_pass_cnt + 1'b1;
            r_pass_flip <= 1'b0;
            r_r1        <= '0;
            r_r2        <= RW'(1);
            r_c1        <= '0;
            r_c2        <= CW'(1);
            if (!w_pass_flip) begin
              r_conv      <= 1'b1;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if ((r_pass_cnt + 1'b1) == P_MAX) begin
              r_conv      <= 1'b0;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign out_valid  = r_out_valid;
  assign m_out      = r_mat;
  assign flip_count = r_flip_cnt;
  assign pass_count = r_pass_cnt;
  assign converged  = r_conv;

endmodule

// File: tb/tb_rect_flip_sequencer.sv
// Self-checking bench for rect_flip_sequencer: directed cases, handshake/reset cases and
// random jobs compared against a grid-based reference model.
module tb_rect_flip_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] m_in = '0;
  logic        rule = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] m_out;
  logic [15:0] flip_count;
  logic [3:0]  pass_count;
  logic        converged;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_m_in = '0;
  logic        b_rule = 1'b0;
  logic        b_busy;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [15:0] b_m_out;
  logic [15:0] b_flip_count;
  logic [0:0]  b_pass_count;
  logic        b_converged;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rect_flip_sequencer #(.ROWS(4), .COLS(4), .MAX_PASSES(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .m_in(m_in), .rule(rule), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .m_out(m_out), .flip_count(flip_count),
    .pass_count(pass_count), .converged(converged)
  );

  rect_flip_sequencer #(.ROWS(4), .COLS(4), .MAX_PASSES(1), .CNT_W(16)) dut_mp1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .m_in(b_m_in), .rule(b_rule), .busy(b_busy), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .m_out(b_m_out), .flip_count(b_flip_count),
    .pass_count(b_pass_count), .converged(b_converged)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: grid of ints, full passes in rectangle order, stop on a clean pass or the limit.
  task automatic model(input logic [15:0] m, input bit rl, input int maxp,
                       output logic [15:0] mo, output int fl, output int ps, output bit cv);
    int  g[4][4];
    int  n;
    bit  any;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        g[r][c] = int'(m[15 - (r * 4 + c)]);
    fl = 0;
    ps = 0;
    cv = 1'b0;
    while (1) begin
      any = 1'b0;
      for (int r1 = 0; r1 < 3; r1++)
        for (int r2 = r1 + 1; r2 < 4; r2++)
          for (int c1 = 0; c1 < 3; c1++)
            for (int c2 = c1 + 1; c2 < 4; c2++) begin
              n = g[r1][c1] + g[r1][c2] + g[r2][c1] + g[r2][c2];
              if ((rl && n >= 3) || (!rl && n == 4)) begin
                g[r1][c1] = 1 - g[r1][c1];
                g[r1][c2] = 1 - g[r1][c2];
                g[r2][c1] = 1 - g[r2][c1];
                g[r2][c2] = 1 - g[r2][c2];
                fl++;
                any = 1'b1;
              end
            end
      ps++;
      if (!any) begin
        cv = 1'b1;
        break;
      end
      if (ps == maxp) begin
        cv = 1'b0;
        break;
      end
    end
    mo = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mo[15 - (r * 4 + c)] = g[r][c][0];
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge that releases DONE.
  task automatic run_job(input string tag, input logic [15:0] m, input bit rl,
                         input int hold, input bit inject,
                         output logic [15:0] om, output int ofc, output int opc,
                         output bit ocv, output int lat);
    logic [15:0] em;
    int          efl, eps;
    bit          ecv;
    model(m, rl, 8, em, efl, eps, ecv);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    m_in     = m;
    rule     = rl;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_scan"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 400) begin
      if (inject && lat == 5) begin
        in_valid = 1'b1;
        m_in     = ~m;
        rule     = ~rl;
      end
      if (inject && lat == 9) in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    om  = m_out;
    ofc = int'(flip_count);
    opc = int'(pass_count);
    ocv = converged;
    chk({tag, "_m_out"}, 32'(m_out), 32'(em));
    chk({tag, "_flip_count"}, 32'(flip_count), 32'(efl));
    chk({tag, "_pass_count"}, 32'(pass_count), 32'(eps));
    chk({tag, "_converged"}, 32'(converged), 32'(ecv));
    chk({tag, "_latency"}, 32'(lat), 32'(eps * 36 + 1));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_m_out"}, 32'(m_out), 32'(em));
      chk({tag, "_hold_flips"}, 32'(flip_count), 32'(efl));
      chk({tag, "_hold_passes"}, 32'(pass_count), 32'(eps));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_keep_m_out"}, 32'(m_out), 32'(em));
  endtask

  initial begin
    logic [15:0] om, rm;
    int          fc, pc, lat, n;
    bit          cv;
    int          efl, eps;
    bit          ecv;
    logic [15:0] em;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_m_out", 32'(m_out), 32'd0);
    chk("rst_flip_count", 32'(flip_count), 32'd0);
    chk("rst_pass_count", 32'(pass_count), 32'd0);
    chk("rst_converged", 32'(converged), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job("zero", 16'h0000, 1'b0, 0, 1'b0, om, fc, pc, cv, lat);
    chk("zero_m", 32'(om), 32'h0000);
    chk("zero_fc", 32'(fc), 32'd0);
    chk("zero_pc", 32'(pc), 32'd1);
    chk("zero_cv", 32'(cv), 32'd1);
    chk("zero_lat", 32'(lat), 32'd37);

    run_job("ones", 16'hFFFF, 1'b0, 0, 1'b0, om, fc, pc, cv, lat);
    chk("ones_m", 32'(om), 32'h0000);
    chk("ones_fc", 32'(fc), 32'd4);
    chk("ones_pc", 32'(pc), 32'd2);
    chk("ones_cv", 32'(cv), 32'd1);
    chk("ones_lat", 32'(lat), 32'd73);

    run_job("h9009", 16'h9009, 1'b0, 0, 1'b0, om, fc, pc, cv, lat);
    chk("h9009_m", 32'(om), 32'h0000);
    chk("h9009_fc", 32'(fc), 32'd1);
    chk("h9009_pc", 32'(pc), 32'd2);

    run_job("h9008r0", 16'h9008, 1'b0, 0, 1'b0, om, fc, pc, cv, lat);
    chk("h9008r0_m", 32'(om), 32'h9008);
    chk("h9008r0_fc", 32'(fc), 32'd0);
    chk("h9008r0_pc", 32'(pc), 32'd1);

    run_job("h9008r1", 16'h9008, 1'b1, 0, 1'b0, om, fc, pc, cv, lat);
    chk("h9008r1_m", 32'(om), 32'h0001);
    chk("h9008r1_fc", 32'(fc), 32'd1);
    chk("h9008r1_pc", 32'(pc), 32'd2);
    chk("h9008r1_cv", 32'(cv), 32'd1);

    // Pass-limited instance.
    b_in_valid = 1'b1;
    b_m_in     = 16'hFFFF;
    b_rule     = 1'b0;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    model(16'hFFFF, 1'b0, 1, em, efl, eps, ecv);
    chk("mp1_out_valid", 32'(b_out_valid), 32'd1);
    chk("mp1_m", 32'(b_m_out), 32'h0000);
    chk("mp1_m_model", 32'(b_m_out), 32'(em));
    chk("mp1_fc", 32'(b_flip_count), 32'd4);
    chk("mp1_pc", 32'(b_pass_count), 32'd1);
    chk("mp1_cv", 32'(b_converged), 32'd0);
    chk("mp1_cv_model", 32'(b_converged), 32'(ecv));
    chk("mp1_lat", 32'(n), 32'd37);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("mp1_release", 32'(b_out_valid), 32'd0);

    run_job("hold", 16'hFFFF, 1'b0, 10, 1'b0, om, fc, pc, cv, lat);
    run_job("inject", 16'h9009, 1'b0, 2, 1'b1, om, fc, pc, cv, lat);
    chk("inject_m", 32'(om), 32'h0000);

    // Reset during SCAN.
    in_valid = 1'b1;
    m_in     = 16'hFFFF;
    rule     = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_m_out", 32'(m_out), 32'd0);
    chk("mid_rst_flips", 32'(flip_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_pass", 32'(pass_count), 32'd0);

    for (int k = 0; k < 25; k++) begin
      rm = 16'($urandom);
      run_job("rand", rm, 1'($urandom_range(0, 1)), 0, 1'b0, om, fc, pc, cv, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
